// File: rtl/pixel_writer.sv
// pixel_writer: buffers (x,y,colour) pixels and read-modify-writes them into a
// 1-bpp packed framebuffer SRAM through the shared-memory arbiter.  Rev 1.0
`default_nettype none

module pixel_writer #(
  parameter int H_RES        = 640,
  parameter int V_RES        = 480,
  parameter int ADDR_W       = 15,
  parameter int FIFO_DEPTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_valid,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  input  logic              colour,
  output logic              stall,
  output logic              busy,
  output logic              overflow,
  output logic              sram_req,
  output logic              sram_we,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [15:0]       sram_wdata,
  input  logic [15:0]       sram_rdata,
  input  logic              sram_grant
);

  localparam int PTR_W          = $clog2(FIFO_DEPTH);
  localparam int CNT_W          = $clog2(FIFO_DEPTH + 1);
  localparam int LAT_W          = $clog2(READ_LATENCY + 1);
  localparam int ENTRY_W        = ADDR_W + 5;
  localparam int WORDS_PER_LINE = H_RES / 16;
  localparam logic [10:0] H_LIM = 11'(H_RES);
  localparam logic [10:0] V_LIM = 11'(V_RES);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_REQ  = 2'd1,
    RD_WAIT = 2'd2,
    WR_REQ  = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [LAT_W-1:0]     lat_q, lat_d;
  logic [15:0]          word_q, word_d;

  logic [ENTRY_W-1:0]   fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]     count_q;
  logic                 overflow_q;

  logic                 w_in_range;
  logic                 w_push;
  logic                 w_pop;
  logic [ADDR_W-1:0]    w_addr;
  logic [ENTRY_W-1:0]   w_entry;
  logic [ENTRY_W-1:0]   w_head;
  logic [ADDR_W-1:0]    w_head_addr;
  logic [3:0]           w_head_bit;
  logic                 w_head_colour;

  // Stall comes from the registered count only, so a same-cycle pop never frees a slot early.
  assign stall      = (count_q == CNT_W'(FIFO_DEPTH));
  assign busy       = (count_q != '0) || (state_q != IDLE);
  assign overflow   = overflow_q;

  assign w_in_range = ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
  assign w_push     = pix_valid && !stall && w_in_range;
  assign w_addr     = ADDR_W'(32'(y) * 32'(WORDS_PER_LINE) + 32'(x[9:4]));
  assign w_entry    = {w_addr, x[3:0], colour};

  assign w_head        = fifo_q[rd_ptr_q];
  assign w_head_addr   = w_head[ENTRY_W-1:5];
  assign w_head_bit    = w_head[4:1];
  assign w_head_colour = w_head[0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_q[wr_ptr_q] <= w_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (w_push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (pix_valid && stall) begin
        overflow_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      lat_q   <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lat_d      = lat_q;
    word_d     = word_q;
    w_pop      = 1'b0;
    sram_req   = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state_q)
      IDLE: begin
        // A push into an empty FIFO is already at the head next cycle.
        if ((count_q != '0) || w_push) begin
          state_d = RD_REQ;
        end
      end
      RD_REQ: begin
        sram_req  = 1'b1;
        sram_addr = w_head_addr;
        if (sram_grant) begin
          lat_d   = LAT_W'(1);
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (lat_q == LAT_W'(READ_LATENCY)) begin
          word_d             = sram_rdata;
          word_d[w_head_bit] = w_head_colour;
          state_d            = WR_REQ;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      WR_REQ: begin
        sram_req   = 1'b1;
        sram_we    = 1'b1;
        sram_addr  = w_head_addr;
        sram_wdata = word_q;
        if (sram_grant) begin
          w_pop   = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pixel_writer.sv
// tb_pixel_writer: directed stimulus with an SRAM model and an expected-write scoreboard.
`default_nettype none

module tb_pixel_writer;

  localparam int L = 2;

  typedef struct {
    logic [14:0] addr;
    logic [3:0]  bitn;
    logic        col;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        pix_valid;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        colour;
  logic        stall;
  logic        busy;
  logic        overflow;
  logic        sram_req;
  logic        sram_we;
  logic [14:0] sram_addr;
  logic [15:0] sram_wdata;
  logic [15:0] sram_rdata = 16'hDEAD;
  logic        sram_grant;

  exp_t        sb[$];
  bit [15:0]   mem [int];
  int          n_pass   = 0;
  int          n_total  = 0;
  int          n_writes = 0;
  int          rd_cnt   = 0;
  int          rd_addr  = 0;
  int          last_waddr = -1;
  logic [15:0] last_wdata = '0;
  int          nw;

  pixel_writer #(
    .H_RES(640), .V_RES(480), .ADDR_W(15), .FIFO_DEPTH(8), .READ_LATENCY(L)
  ) dut (
    .clk(clk), .reset(reset), .pix_valid(pix_valid), .x(x), .y(y), .colour(colour),
    .stall(stall), .busy(busy), .overflow(overflow),
    .sram_req(sram_req), .sram_we(sram_we), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata), .sram_grant(sram_grant)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic bit [15:0] rd(input int a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  // SRAM/arbiter model: read data is valid only in the cycle READ_LATENCY after the grant.
  always @(negedge clk) begin
    exp_t        e;
    logic [15:0] w;
    if (rd_cnt > 0) begin
      rd_cnt--;
      sram_rdata = (rd_cnt == 0) ? rd(rd_addr) : 16'hDEAD;
    end else begin
      sram_rdata = 16'hDEAD;
    end
    if (!reset && sram_req && sram_grant) begin
      if (!sram_we) begin
        check("rd_addr", 32'(sram_addr), sb.size() > 0 ? 32'(sb[0].addr) : 32'hFFFF_FFFF);
        rd_addr = int'(sram_addr);
        rd_cnt  = L;
      end else begin
        if (sb.size() > 0) begin
          e = sb.pop_front();
          w = rd(int'(e.addr));
          w[e.bitn] = e.col;
          check("wr_addr", 32'(sram_addr), 32'(e.addr));
          check("wr_data", 32'(sram_wdata), 32'(w));
        end else begin
          check("wr_unexpected", 32'(sram_addr), 32'hFFFF_FFFF);
        end
        mem[int'(sram_addr)] = sram_wdata;
        n_writes++;
        last_waddr = int'(sram_addr);
        last_wdata = sram_wdata;
      end
    end
  end

  task automatic send(input int px, input int py, input logic c);
    int   g = 0;
    exp_t e;
    while (stall === 1'b1 && g < 300) begin
      @(posedge clk); #1;
      g++;
    end
    if (g >= 300) check("send_stall_timeout", 32'(stall), 32'h0);
    x = 10'(px); y = 10'(py); colour = c; pix_valid = 1'b1;
    if (stall === 1'b0 && px < 640 && py < 480) begin
      e.addr = 15'(py * 40 + px / 16);
      e.bitn = 4'(px % 16);
      e.col  = c;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    pix_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int g = 0;
    while (busy !== 1'b0 && g < 500) begin
      @(posedge clk); #1;
      g++;
    end
    check(tag, 32'(busy), 32'h0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pix_valid = 1'b0; x = '0; y = '0; colour = 1'b0; sram_grant = 1'b0;
    cycles(3);
    reset = 1'b0;
    check("rst_stall", 32'(stall), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_req", 32'(sram_req), 0);
    check("rst_we", 32'(sram_we), 0);
    check("rst_addr", 32'(sram_addr), 0);
    check("rst_wdata", 32'(sram_wdata), 0);

    // Single pixel, set bit 3 of word 0
    sram_grant = 1'b1;
    mem[0] = 16'h0000;
    send(3, 0, 1'b1);
    check("t1_req_next_cycle", 32'(sram_req), 1);
    check("t1_read_first", 32'(sram_we), 0);
    check("t1_busy", 32'(busy), 1);
    wait_idle("t1_idle");
    check("t1_waddr", 32'(last_waddr), 0);
    check("t1_wdata", 32'(last_wdata), 32'h0008);

    // Bottom-right pixel, clear bit 15
    mem[19199] = 16'hFFFF;
    send(639, 479, 1'b0);
    wait_idle("t2_idle");
    check("t2_waddr", 32'(last_waddr), 19199);
    check("t2_wdata", 32'(last_wdata), 32'h7FFF);

    // Grant held low: fill the FIFO, then drain in order
    sram_grant = 1'b0;
    nw = n_writes;
    for (int i = 0; i < 8; i++) send(i * 5, 2, 1'b1);
    check("t3_stall_full", 32'(stall), 1);
    cycles(5);
    check("t3_stall_held", 32'(stall), 1);
    check("t3_no_overflow", 32'(overflow), 0);
    check("t3_no_writes", 32'(n_writes - nw), 0);
    check("t3_req_held", 32'(sram_req), 1);
    check("t3_req_addr", 32'(sram_addr), 80);
    sram_grant = 1'b1;
    send(40, 2, 1'b1);
    send(45, 2, 1'b1);
    wait_idle("t3_idle");
    check("t3_write_count", 32'(n_writes - nw), 10);
    check("t3_sb_empty", 32'(sb.size()), 0);
    check("t3_overflow_end", 32'(overflow), 0);

    // Out-of-range pixels are discarded
    nw = n_writes;
    send(640, 5, 1'b1);
    send(0, 480, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_req_low", 32'(sram_req), 0);
      check("t4_busy_low", 32'(busy), 0);
    end
    check("t4_no_writes", 32'(n_writes - nw), 0);

    // Push while full: dropped, overflow sticky until reset
    @(posedge clk); #1;
    sram_grant = 1'b0;
    nw = n_writes;
    for (int i = 0; i < 8; i++) send(100 + i, 7, 1'(i));
    check("t5_stall_full", 32'(stall), 1);
    check("t5_overflow_before", 32'(overflow), 0);
    x = 10'd1; y = 10'd1; colour = 1'b1; pix_valid = 1'b1;
    @(posedge clk); #1;
    pix_valid = 1'b0;
    check("t5_overflow_set", 32'(overflow), 1);
    sram_grant = 1'b1;
    wait_idle("t5_idle");
    check("t5_write_count", 32'(n_writes - nw), 8);
    check("t5_overflow_sticky", 32'(overflow), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("t5_overflow_cleared", 32'(overflow), 0);

    // Reset while waiting for read data: the access is abandoned
    send(20, 3, 1'b1);
    begin
      int g = 0;
      while (!(sram_req === 1'b1 && sram_we === 1'b0) && g < 20) begin
        @(negedge clk);
        g++;
      end
      check("t6_read_seen", 32'(sram_req), 1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    sb.delete();
    nw = n_writes;
    check("t6_req_low", 32'(sram_req), 0);
    check("t6_busy_low", 32'(busy), 0);
    check("t6_stall_low", 32'(stall), 0);
    cycles(10);
    check("t6_no_write", 32'(n_writes - nw), 0);
    check("t6_req_still_low", 32'(sram_req), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
